// File: rtl/period_packetizer_if.sv
// Byte-wide valid/ready stream carrying period_packetizer frames.
// Latency: none, wires only.
// Backpressure: the slave holds byte_rdy low to stall; the master keeps byte_dat stable meanwhile.
// Signals: byte_dat - packet byte, byte_vld - byte_dat is valid, byte_rdy - slave accepts this cycle.
interface period_packetizer_if;
  logic [7:0] byte_dat;
  logic       byte_vld;
  logic       byte_rdy;

  modport master (output byte_dat, output byte_vld, input byte_rdy);
  modport slave  (input byte_dat, input byte_vld, output byte_rdy);
endinterface

// File: rtl/period_packetizer.sv
// Snapshots per-pixel PERIOD words and emits a header/mask/data[/checksum] byte frame.
// Latency: header valid one cycle after START is accepted; one byte per cycle with ready held high.
// Backpressure: byte_rdy low freezes the current byte and valid; no combinational rdy->dat/vld path.
//
// Ports:
//   i_clk, i_rst     - rising-edge clock, synchronous active-high reset
//   i_period         - packed period words, pixel i at [i*COUNTER_BITS +: COUNTER_BITS]
//   i_pulse          - per-pixel strobe: word i is new this cycle
//   i_start          - frame request, only honoured in IDLE
//   o_byte           - output byte stream (master side of period_packetizer_if)
//   o_busy           - high from START acceptance until the last byte is transferred
//   o_frame_done     - one-cycle pulse the cycle after the final transfer
// Build option: define PACKET_CHECKSUM_EN to append an XOR checksum byte to each frame.
module period_packetizer #(
  parameter int         PIXELS       = 8,
  parameter int         COUNTER_BITS = 12,
  parameter logic [7:0] HEADER_BYTE  = 8'hA5
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [PIXELS*COUNTER_BITS-1:0] i_period,
  input  logic [PIXELS-1:0]              i_pulse,
  input  logic                           i_start,
  period_packetizer_if.master            o_byte,
  output logic                           o_busy,
  output logic                           o_frame_done
);

  localparam int BPW  = (COUNTER_BITS + 7) / 8;
  localparam int PIXW = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam int BSW  = (BPW > 1) ? $clog2(BPW) : 1;

`ifdef PACKET_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_MASK, S_DATA, S_CSUM} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_MASK, S_DATA} state_t;
`endif

  state_t                  r_state;
  logic [COUNTER_BITS-1:0] r_shadow [PIXELS];
  logic [COUNTER_BITS-1:0] r_fbuf   [PIXELS];
  logic [PIXELS-1:0]       r_upd;
  logic [PIXELS-1:0]       r_mask;
  logic [PIXW-1:0]         r_pix;
  logic [BSW-1:0]          r_bsel;
  logic [7:0]              r_dat;
  logic                    r_vld;
  logic                    r_busy;
  logic                    r_done;
`ifdef PACKET_CHECKSUM_EN
  logic [7:0]              r_csum;
`endif

  logic                    w_xfer;
  logic                    w_last;
  logic [PIXW-1:0]         w_nxt_pix;
  logic [BSW-1:0]          w_nxt_bsel;
  logic [COUNTER_BITS-1:0] w_word;
  logic [BPW*8-1:0]        w_word_pad;
  logic [7:0]              w_nxt_byte;
  logic [7:0]              w_mask_byte;

  assign w_xfer = r_vld && o_byte.byte_rdy;
  assign w_last = (int'(r_pix) == PIXELS - 1) && (int'(r_bsel) == BPW - 1);

  // Byte that follows the one currently presented: from MASK this is the
  // first data byte, from DATA it is the next byte of the walk.
  always_comb begin
    w_nxt_pix  = '0;
    w_nxt_bsel = '0;
    if (r_state == S_DATA) begin
      if (int'(r_bsel) == BPW - 1) begin
        w_nxt_pix  = r_pix + 1'b1;
        w_nxt_bsel = '0;
      end else begin
        w_nxt_pix  = r_pix;
        w_nxt_bsel = r_bsel + 1'b1;
      end
    end
    // Past the last pixel the value is never used; keep the index in range.
    w_word = (int'(w_nxt_pix) < PIXELS) ? r_fbuf[w_nxt_pix] : '0;
    w_word_pad = (BPW*8)'(w_word);
    // Most-significant byte first within each word.
    w_nxt_byte = '0;
    for (int b = 0; b < BPW; b++) begin
      if (int'(w_nxt_bsel) == b) w_nxt_byte = w_word_pad[(BPW-1-b)*8 +: 8];
    end
    w_mask_byte = '0;
    w_mask_byte[PIXELS-1:0] = r_mask;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      for (int i = 0; i < PIXELS; i++) begin
        r_shadow[i] <= '0;
        r_fbuf[i]   <= '0;
      end
      r_upd  <= '0;
      r_mask <= '0;
      r_pix  <= '0;
      r_bsel <= '0;
      r_dat  <= '0;
      r_vld  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
`ifdef PACKET_CHECKSUM_EN
      r_csum <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      // Shadow capture runs in every state; the frame buffer stays frozen.
      for (int i = 0; i < PIXELS; i++) begin
        if (i_pulse[i]) r_shadow[i] <= i_period[i*COUNTER_BITS +: COUNTER_BITS];
      end
      r_upd <= r_upd | i_pulse;
`ifdef PACKET_CHECKSUM_EN
      if (w_xfer) r_csum <= r_csum ^ r_dat;
`endif

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            // Snapshot takes the pre-edge shadow/upd; a pulse in this same
            // cycle lands in shadow and re-arms upd for the next frame.
            for (int i = 0; i < PIXELS; i++) r_fbuf[i] <= r_shadow[i];
            r_mask  <= r_upd;
            r_upd   <= i_pulse;
            r_dat   <= HEADER_BYTE;
            r_vld   <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_HEADER;
`ifdef PACKET_CHECKSUM_EN
            r_csum  <= '0;
`endif
          end
        end

        S_HEADER: begin
          if (w_xfer) begin
            r_dat   <= w_mask_byte;
            r_state <= S_MASK;
          end
        end

        S_MASK: begin
          if (w_xfer) begin
            r_dat   <= w_nxt_byte;
            r_pix   <= '0;
            r_bsel  <= '0;
            r_state <= S_DATA;
          end
        end

        S_DATA: begin
          if (w_xfer) begin
            if (w_last) begin
`ifdef PACKET_CHECKSUM_EN
              // r_csum has not yet absorbed the byte leaving now.
              r_dat   <= r_csum ^ r_dat;
              r_state <= S_CSUM;
`else
              r_dat   <= '0;
              r_vld   <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
`endif
            end else begin
              r_dat  <= w_nxt_byte;
              r_pix  <= w_nxt_pix;
              r_bsel <= w_nxt_bsel;
            end
          end
        end

`ifdef PACKET_CHECKSUM_EN
        S_CSUM: begin
          if (w_xfer) begin
            r_dat   <= '0;
            r_vld   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
`endif

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_byte.byte_dat = r_dat;
  assign o_byte.byte_vld = r_vld;
  assign o_busy          = r_busy;
  assign o_frame_done    = r_done;

endmodule

// File: tb/tb_period_packetizer.sv
module tb_period_packetizer;

`ifdef PACKET_CHECKSUM_EN
  localparam int FLEN = 19;
`else
  localparam int FLEN = 18;
`endif

  logic        clk;
  logic        rst;
  logic [95:0] period;
  logic [7:0]  pulse;
  logic        start;
  logic        busy;
  logic        frame_done;

  period_packetizer_if bus ();

  period_packetizer #(
    .PIXELS(8), .COUNTER_BITS(12), .HEADER_BYTE(8'hA5)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_period(period), .i_pulse(pulse),
    .i_start(start), .o_byte(bus), .o_busy(busy), .o_frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0]  got [$];
  logic [7:0]  expq [$];
  logic [11:0] bw [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_words(input logic [7:0] msk, input logic [11:0] w [8]);
    for (int i = 0; i < 8; i++) period[i*12 +: 12] = w[i];
    pulse = msk;
    step();
    pulse = '0;
  endtask

  // Reference frame for 8 pixels x 12 bits.
  task automatic build_exp(input logic [11:0] w [8], input logic [7:0] m);
    logic [7:0] x;
    expq.delete();
    expq.push_back(8'hA5);
    expq.push_back(m);
    for (int i = 0; i < 8; i++) begin
      expq.push_back({4'b0, w[i][11:8]});
      expq.push_back(w[i][7:0]);
    end
`ifdef PACKET_CHECKSUM_EN
    x = '0;
    foreach (expq[k]) x = x ^ expq[k];
    expq.push_back(x);
`endif
  endtask

  // Called right after START was accepted. mode 0: ready always high;
  // mode 1: ready low 3 cycles on the mask byte, random afterwards.
  task automatic collect_frame(input int mode, output int ncyc, output bit timeout);
    bit         prev_hold;
    logic [7:0] prev_dat;
    logic [7:0] d;
    logic       v, r;
    int         stall;
    got.delete();
    ncyc = 0; timeout = 0; prev_hold = 0; prev_dat = '0; stall = 0;
    forever begin
      if (ncyc >= 300) begin
        timeout = 1;
        break;
      end
      if (mode == 0 || got.size() == 0) bus.byte_rdy = 1'b1;
      else if (got.size() == 1 && stall < 3) begin
        bus.byte_rdy = 1'b0;
        stall++;
      end else bus.byte_rdy = ($urandom_range(0, 2) != 0);
      if (prev_hold) begin
        total_cnt++;
        if (bus.byte_vld !== 1'b1 || bus.byte_dat !== prev_dat)
          $display("FAIL hold_stable: vld=%b dat=%h expected vld=1 dat=%h",
                   bus.byte_vld, bus.byte_dat, prev_dat);
        else pass_cnt++;
      end
      v = bus.byte_vld; d = bus.byte_dat; r = bus.byte_rdy;
      step();
      ncyc++;
      if (v && r) got.push_back(d);
      prev_hold = v && !r;
      prev_dat  = d;
      if (frame_done) break;
    end
    bus.byte_rdy = 1'b1;
  endtask

  task automatic start_frame(input string name);
    start = 1'b1;
    step();
    start = 1'b0;
    total_cnt++;
    if (busy !== 1'b1 || bus.byte_vld !== 1'b1 || bus.byte_dat !== 8'hA5)
      $display("FAIL %s_start: busy=%b vld=%b dat=%h expected 1 1 a5",
               name, busy, bus.byte_vld, bus.byte_dat);
    else pass_cnt++;
  endtask

  task automatic check_frame(input string name, input int ncyc, input bit timeout);
    total_cnt++;
    if (timeout) $display("FAIL %s_timeout: no FRAME_DONE within budget", name);
    else pass_cnt++;
    total_cnt++;
    if (got.size() != FLEN) $display("FAIL %s_len: got %0d bytes expected %0d", name, got.size(), FLEN);
    else pass_cnt++;
    for (int k = 0; k < FLEN && k < got.size(); k++) begin
      total_cnt++;
      if (got[k] !== expq[k]) $display("FAIL %s_byte%0d: got %h expected %h", name, k, got[k], expq[k]);
      else pass_cnt++;
    end
    total_cnt++;
    if (busy !== 1'b0 || bus.byte_vld !== 1'b0)
      $display("FAIL %s_end: busy=%b vld=%b at FRAME_DONE expected 0 0", name, busy, bus.byte_vld);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      total_cnt++;
      if (bus.byte_vld !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || bus.byte_dat !== 8'h00)
        $display("FAIL reset_c%0d: vld=%b busy=%b done=%b dat=%h expected all 0",
                 c, bus.byte_vld, busy, frame_done, bus.byte_dat);
      else pass_cnt++;
    end
    rst = 1'b0; start = 1'b0;
    step();
    total_cnt++;
    if (bus.byte_vld !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_idle: vld=%b busy=%b expected 0 0", bus.byte_vld, busy);
    else pass_cnt++;
  endtask

  task automatic test_basic_frame();
    int ncyc; bit to;
    for (int i = 0; i < 8; i++) bw[i] = 12'(i * 257);
    pulse_words(8'hFF, bw);
    start_frame("basic");
    collect_frame(0, ncyc, to);
    build_exp(bw, 8'hFF);
    check_frame("basic", ncyc, to);
    total_cnt++;
    if (ncyc != FLEN) $display("FAIL basic_cycles: FRAME_DONE at cycle %0d expected %0d", ncyc, FLEN);
    else pass_cnt++;
    total_cnt++;
    if (got.size() > 7 && (got[6] !== 8'h02 || got[7] !== 8'h02))
      $display("FAIL basic_pix2: got %h %h expected 02 02", got[6], got[7]);
    else if (got.size() <= 7) $display("FAIL basic_pix2: frame too short (%0d)", got.size());
    else pass_cnt++;
`ifdef PACKET_CHECKSUM_EN
    total_cnt++;
    if (got.size() == 19 && got[18] !== 8'h5A) $display("FAIL basic_csum: got %h expected 5a", got[18]);
    else if (got.size() != 19) $display("FAIL basic_csum: frame length %0d", got.size());
    else pass_cnt++;
`endif
    step();
    total_cnt++;
    if (frame_done !== 1'b0) $display("FAIL done_pulse: FRAME_DONE=%b one cycle later expected 0", frame_done);
    else pass_cnt++;
  endtask

  task automatic test_stale_mask();
    int ncyc; bit to;
    logic [11:0] w [8];
    w = bw;
    w[0] = 12'hFED;
    w[5] = 12'h05A;
    pulse_words(8'h21, w);
    start_frame("stale");
    collect_frame(0, ncyc, to);
    build_exp(w, 8'h21);
    check_frame("stale", ncyc, to);
    // Restart in the FRAME_DONE cycle.
    start_frame("restart");
    collect_frame(0, ncyc, to);
    build_exp(w, 8'h00);
    check_frame("restart", ncyc, to);
    bw = w;
  endtask

  task automatic test_backpressure();
    int ncyc; bit to;
    for (int i = 0; i < 8; i++) bw[i] = 12'(i * 257);
    pulse_words(8'hFF, bw);
    start_frame("bp");
    collect_frame(1, ncyc, to);
    build_exp(bw, 8'hFF);
    check_frame("bp", ncyc, to);
    total_cnt++;
    if (ncyc < FLEN + 3) $display("FAIL bp_cycles: frame took %0d cycles expected at least %0d", ncyc, FLEN + 3);
    else pass_cnt++;
  endtask

  task automatic test_collision();
    int ncyc; bit to;
    logic [11:0] w [8];
    w = bw;
    w[2] = 12'h111;
    pulse_words(8'h04, w);
    period[2*12 +: 12] = 12'hABC;
    pulse = 8'h04;
    start_frame("coll");
    pulse = '0;
    collect_frame(0, ncyc, to);
    build_exp(w, 8'h04);
    check_frame("coll", ncyc, to);
    total_cnt++;
    if (got.size() > 7 && (got[6] !== 8'h01 || got[7] !== 8'h11))
      $display("FAIL coll_old: got %h %h expected 01 11", got[6], got[7]);
    else if (got.size() <= 7) $display("FAIL coll_old: frame too short (%0d)", got.size());
    else pass_cnt++;
    step();
    w[2] = 12'hABC;
    start_frame("coll2");
    collect_frame(0, ncyc, to);
    build_exp(w, 8'h04);
    check_frame("coll2", ncyc, to);
  endtask

  task automatic test_midframe_reset();
    int ncyc; bit to;
    logic [11:0] z [8];
    start_frame("mid");
    bus.byte_rdy = 1'b1;
    for (int c = 0; c < 7; c++) step();
    rst = 1'b1;
    step();
    total_cnt++;
    if (bus.byte_vld !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || bus.byte_dat !== 8'h00)
      $display("FAIL mid_abort: vld=%b busy=%b done=%b dat=%h expected all 0",
               bus.byte_vld, busy, frame_done, bus.byte_dat);
    else pass_cnt++;
    rst = 1'b0;
    step();
    total_cnt++;
    if (frame_done !== 1'b0 || bus.byte_vld !== 1'b0)
      $display("FAIL mid_nodone: done=%b vld=%b expected 0 0", frame_done, bus.byte_vld);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) z[i] = '0;
    start_frame("post");
    collect_frame(0, ncyc, to);
    build_exp(z, 8'h00);
    check_frame("post", ncyc, to);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pulse = '0; period = '0; bus.byte_rdy = 1'b0;
    test_reset();
    test_basic_frame();
    test_stale_mask();
    test_backpressure();
    test_collision();
    test_midframe_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
